pc_next_unit: RTL
=================

# pc_next_unit

Parametrised next-PC generator and program-counter register for the RISC-V core. It replaces single-source target selection with prioritised selection among NUM_TGT redirect targets, a trap vector and the sequential PC. It holds the PC under stall and buffers one redirect that arrives while stalled, so no redirect is lost. It sits between the branch/jump target adders and the instruction-memory address port.

## Interface
- XLEN, 32, address width
- NUM_TGT, 2, redirect target sources; index 0 is highest priority
- INC, 4, sequential increment in bytes
- ALIGN, 4, required target alignment in bytes, a power of two of at least 2
- RESET_VEC, 32'h0000_0000, PC value after reset
- MISALIGN_VEC, 32'h0000_0004, PC loaded on a misaligned redirect

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- stall  in  1  hold PC this cycle
- tgtValid  in  NUM_TGT  per-source redirect request
- tgtAddr  in  NUM_TGT*XLEN  packed targets; source i occupies bits [i*XLEN +: XLEN]
- trapValid  in  1  trap redirect request
- trapVec  in  XLEN  trap target; bits [log2(ALIGN)-1:0] are forced to 0
- pc  out  XLEN  current PC, registered
- pcPlusInc  out  XLEN  pc+INC, combinational, wraps modulo 2^XLEN
- redirectPending  out  1  a buffered redirect is waiting, registered
- misalign  out  1  one-cycle pulse, registered
- misalignAddr  out  XLEN  offending target, valid while misalign=1

## Operation
- **Candidate order, highest priority first:**
  1. current trap
  2. pending trap
  3. current tgt[i], lowest i wins
  4. pending target
  5. sequential pcPlusInc
- **Unstalled cycle:** pc <= winning candidate. The pending slot clears.
- **Stalled cycle:** pc holds.
  - Capture into the pending slot with kind {TRAP, TGT}.
  - A current trap always overwrites the slot.
  - A current tgt overwrites only an empty slot or a TGT slot. It never overwrites a TRAP slot.
  - With no valid input, the slot is unchanged.
- **Misalignment:** a winning TGT candidate (current or pending) with addr[log2(ALIGN)-1:0] != 0 is not loaded.
  - pc <= MISALIGN_VEC.
  - misalign=1 and misalignAddr=target on the next cycle.
  - Trap candidates can never be misaligned.
- **Simultaneous trap and tgt while stalled:** the slot stores the trap.
- **Simultaneous trap and misaligned tgt, unstalled:** the trap wins and misalign stays 0.
- **pc+INC wrap:** 32'hFFFF_FFFC + 4 = 32'h0000_0000. No flag is raised.

## Timing
- **Reset values:** pc=RESET_VEC, redirectPending=0, misalign=0, misalignAddr=0, pending slot empty.
- **Reset behaviour:** reset asserts asynchronously. Assertion mid-stall discards the pending redirect. The first update happens on the first rising edge after rst_n deasserts.
- **Redirect latency:** a redirect presented in cycle n while unstalled appears on pc in cycle n+1.
- **Buffered redirect:** applied on the edge ending the first unstalled cycle. redirectPending falls on that same edge.
- **redirectPending:** rises on the edge ending the stalled cycle that captured the redirect.
- **misalign:** pulses for exactly one cycle and is never asserted during stall. A misaligned pending target is detected when it is applied.
- **Combinational paths:** pcPlusInc is combinational from pc only. There is no combinational path from any input to any output.

## Structure
- **Package pc_pkg:**
  - enum pcSrc_t {SRC_SEQ, SRC_TGT, SRC_TRAP}
  - struct pending_t {valid, kind, addr}
  - function isAligned(addr, ALIGN)
- **Sub-module pc_prio_enc:** fixed-priority encoder over tgtValid. Outputs anyValid and a one-hot grant; the selected address is the one-hot AND-OR of tgtAddr.
- **Top-level contents:** pc register, pending register, misalign registers, final candidate mux.

## Test plan
- **Reset and sequential:** reset with RESET_VEC=0, then 3 free cycles -> pc 0, 4, 8, 12. redirectPending=0.
- **Priority:** tgtValid=2'b11, tgt0=0x100, tgt1=0x200 -> pc=0x100. Add trapValid with trapVec=0x80 -> pc=0x80.
- **Buffered redirect:**
  - stall 3 cycles at pc=0x20, tgt1=0x400 in the 1st stalled cycle only -> redirectPending=1, pc stays 0x20.
  - Unstall -> pc=0x400, redirectPending=0.
- **Trap beats pending target:**
  - stall, tgt0=0x300 in cycle 1, trap 0x80 in cycle 2, tgt0=0x500 in cycle 3 -> after unstall pc=0x80.
- **Misalignment:** tgt0=0x102 unstalled -> pc=MISALIGN_VEC, misalign=1 for one cycle, misalignAddr=0x102.
- **Wrap and reset mid-stall:**
  - Wrap: pc=0xFFFF_FFFC -> next pc=0x0.
  - Reset mid-stall: capture pending 0x400, pulse rst_n low mid-cycle -> pc=RESET_VEC immediately and redirectPending=0. The next pc after release is RESET_VEC+4.

Source files
------------

// File: rtl/pc_pkg.sv
// pc_pkg: shared types and helpers for the next-PC unit
package pc_pkg;
   localparam int unsigned PC_XLEN = 32;
   typedef enum logic [1:0] {SRC_SEQ, SRC_TGT, SRC_TRAP} pcSrc_t;
   typedef struct packed {
      logic                valid;
      pcSrc_t              kind;
      logic [PC_XLEN-1:0]  addr;
   } pending_t;
   function automatic logic isAligned(input logic [PC_XLEN-1:0] addr, input int unsigned align);
      return (addr & PC_XLEN'(align - 1)) == '0;
   endfunction
endpackage

// File: rtl/pc_prio_enc.sv
// pc_prio_enc: fixed-priority one-hot grant over redirect requests, index 0 highest
//   valid     in  N  per-source request
//   any_valid out 1  at least one request
//   grant     out N  one-hot grant of the lowest-indexed request
module pc_prio_enc #(
   parameter int unsigned N = 2
) (
   input  logic [N-1:0] valid,
   output logic         any_valid,
   output logic [N-1:0] grant
);
   assign any_valid = |valid;
   assign grant     = valid & (~valid + N'(1));
endmodule

// File: rtl/pc_next_unit.sv
// pc_next_unit: prioritised next-PC selection, PC register and one-deep stall redirect buffer
//   clk, rst_n            clock, async active-low reset
//   stall                 hold pc this cycle, buffer any redirect
//   tgtValid, tgtAddr     per-source redirect targets, source 0 highest priority
//   trapValid, trapVec    trap redirect, low alignment bits forced to zero
//   pc, pcPlusInc         registered pc and its sequential successor
//   redirectPending       a buffered redirect is waiting
//   misalign, misalignAddr one-cycle pulse and offending target of a misaligned redirect
module pc_next_unit
   import pc_pkg::*;
#(
   parameter int unsigned     XLEN         = 32,
   parameter int unsigned     NUM_TGT      = 2,
   parameter int unsigned     INC          = 4,
   parameter int unsigned     ALIGN        = 4,
   parameter logic [XLEN-1:0] RESET_VEC    = 32'h0000_0000,
   parameter logic [XLEN-1:0] MISALIGN_VEC = 32'h0000_0004
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    stall,
   input  logic [NUM_TGT-1:0]      tgtValid,
   input  logic [NUM_TGT*XLEN-1:0] tgtAddr,
   input  logic                    trapValid,
   input  logic [XLEN-1:0]         trapVec,
   output logic [XLEN-1:0]         pc,
   output logic [XLEN-1:0]         pcPlusInc,
   output logic                    redirectPending,
   output logic                    misalign,
   output logic [XLEN-1:0]         misalignAddr
);
   localparam logic [XLEN-1:0] LOW_MASK = XLEN'(ALIGN - 1);
   logic               any_tgt;
   logic [NUM_TGT-1:0] grant;
   logic [XLEN-1:0]    tgt_sel;
   logic [XLEN-1:0]    trap_addr;
   logic [XLEN-1:0]    cand_addr;
   pcSrc_t             cand_src;
   logic               pend_trap;
   logic               mis;
   pending_t           pend;
   pc_prio_enc #(.N(NUM_TGT)) u_enc (
      .valid     (tgtValid),
      .any_valid (any_tgt),
      .grant     (grant)
   );
   always_comb begin
      tgt_sel = '0;
      for (int i = 0; i < NUM_TGT; i++)
         tgt_sel = tgt_sel | (tgtAddr[i*XLEN +: XLEN] & {XLEN{grant[i]}});
   end
   assign pcPlusInc       = pc + XLEN'(INC);
   assign trap_addr       = trapVec & ~LOW_MASK;
   assign pend_trap       = pend.valid && pend.kind == SRC_TRAP;
   assign redirectPending = pend.valid;
   always_comb begin
      cand_src  = (trapValid || pend_trap) ? SRC_TRAP : (any_tgt || pend.valid) ? SRC_TGT : SRC_SEQ;
      cand_addr = trapValid  ? trap_addr :
                  pend_trap  ? pend.addr :
                  any_tgt    ? tgt_sel   :
                  pend.valid ? pend.addr : pcPlusInc;
      mis       = cand_src == SRC_TGT && !isAligned(cand_addr, ALIGN);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc           <= RESET_VEC;
         pend         <= '0;
         misalign     <= 1'b0;
         misalignAddr <= '0;
      end else if (!stall) begin
         pc         <= mis ? MISALIGN_VEC : cand_addr;
         pend.valid <= 1'b0;
         misalign   <= mis;
         if (mis) misalignAddr <= cand_addr;
      end else begin
         misalign <= 1'b0;
         if (trapValid) pend <= '{valid: 1'b1, kind: SRC_TRAP, addr: trap_addr};
         else if (any_tgt && !pend_trap) pend <= '{valid: 1'b1, kind: SRC_TGT, addr: tgt_sel};
      end
   end
endmodule
